// File: rtl/tim6_update_ctrl.sv
// ---------------------------------------------------------------------------
// tim6_update_ctrl
// Counting and interrupt-generation core of basic timer TIM6. Takes the CR1
// control bits, DIER.UIE and the PSC/ARR preload values from the register
// file. Produces the counter, the update event, the UIF flag and the IRQ.
//
// Ports
//   clk        system clock
//   rst        synchronous active-low reset
//   i_cen      CR1.CEN counter enable
//   i_udis     CR1.UDIS update disable
//   i_opm      CR1.OPM one-pulse mode
//   i_arpe     CR1.ARPE auto-reload preload enable
//   i_uie      DIER.UIE update interrupt enable
//   i_psc      PSC preload value
//   i_arr      ARR preload value
//   i_ug       EGR.UG software update pulse
//   i_uif_clr  SR.UIF clear strobe
//   o_cnt      current counter value
//   o_uif      SR.UIF status flag
//   o_irq      interrupt request (combinational level)
//   o_uev      update event pulse
//   o_cen_clr  one-cycle request to clear CR1.CEN in one-pulse mode
// ---------------------------------------------------------------------------
module tim6_update_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cen,
   input  logic             i_udis,
   input  logic             i_opm,
   input  logic             i_arpe,
   input  logic             i_uie,
   input  logic [CNT_W-1:0] i_psc,
   input  logic [CNT_W-1:0] i_arr,
   input  logic             i_ug,
   input  logic             i_uif_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_uif,
   output logic             o_irq,
   output logic             o_uev,
   output logic             o_cen_clr
);

   // One-pulse-mode stop: HOLD after an OPM overflow until CEN is seen low.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_OPM_HOLD = 1'b1
   } opm_state_e;

   opm_state_e       state_q, state_d;

   logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] psc_shadow_q, psc_shadow_d;
   logic [CNT_W-1:0] arr_shadow_q, arr_shadow_d;
   logic             uif_q, uif_d;
   logic             uev_q, uev_d;
   logic             cen_clr_q, cen_clr_d;

   logic [CNT_W-1:0] arr_act;
   logic             opm_hold;
   logic             run;
   logic             tick;
   logic             ovf;
   logic             uev_req;
   logic             uev_fire;

   // Event decode shared by the datapath and the OPM state machine.
   always_comb begin
      opm_hold = (state_q == ST_OPM_HOLD);
      arr_act  = i_arpe ? arr_shadow_q : i_arr;
      run      = i_cen & ~opm_hold & ~i_ug;
      tick     = run & (psc_cnt_q == psc_shadow_q);
      // An ARR of zero parks the counter at 0 and never overflows.
      ovf      = tick & (arr_act != '0) & (cnt_q == arr_act);
      uev_req  = ovf | i_ug;
      uev_fire = uev_req & ~i_udis;
   end

   // Prescaler and counter next state; UG overrides any tick.
   always_comb begin
      psc_cnt_d = psc_cnt_q;
      cnt_d     = cnt_q;
      if (i_ug) begin
         psc_cnt_d = '0;
         cnt_d     = '0;
      end else if (run) begin
         if (tick) begin
            psc_cnt_d = '0;
            if (arr_act == '0) begin
               cnt_d = '0;
            end else if (cnt_q == arr_act) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            psc_cnt_d = psc_cnt_q + CNT_W'(1);
         end
      end
   end

   // Update event: shadow reload, UEV pulse and sticky UIF (set beats clear).
   always_comb begin
      psc_shadow_d = psc_shadow_q;
      arr_shadow_d = arr_shadow_q;
      uev_d        = 1'b0;
      uif_d        = uif_q;
      if (i_uif_clr) begin
         uif_d = 1'b0;
      end
      if (uev_fire) begin
         psc_shadow_d = i_psc;
         arr_shadow_d = i_arr;
         uev_d        = 1'b1;
         uif_d        = 1'b1;
      end
   end

   // OPM next state; only a counter overflow (never UG) stops the timer.
   always_comb begin
      state_d   = state_q;
      cen_clr_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (ovf && i_opm) begin
               state_d   = ST_OPM_HOLD;
               cen_clr_d = 1'b1;
            end
         end
         ST_OPM_HOLD: begin
            if (!i_cen) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         psc_cnt_q    <= '0;
         cnt_q        <= '0;
         psc_shadow_q <= '0;
         arr_shadow_q <= '1;
         uif_q        <= 1'b0;
         uev_q        <= 1'b0;
         cen_clr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         psc_cnt_q    <= psc_cnt_d;
         cnt_q        <= cnt_d;
         psc_shadow_q <= psc_shadow_d;
         arr_shadow_q <= arr_shadow_d;
         uif_q        <= uif_d;
         uev_q        <= uev_d;
         cen_clr_q    <= cen_clr_d;
      end
   end

   assign o_cnt     = cnt_q;
   assign o_uif     = uif_q;
   assign o_uev     = uev_q;
   assign o_cen_clr = cen_clr_q;
   // IRQ follows UIE immediately while UIF is pending.
   assign o_irq     = uif_q & i_uie;

endmodule

// File: tb/tb_tim6_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tim6_update_ctrl
// Directed self-checking bench for tim6_update_ctrl with hand-computed
// expected counter, UEV, UIF, IRQ and CEN-clear values.
// ---------------------------------------------------------------------------
module tb_tim6_update_ctrl;

   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             i_cen;
   logic             i_udis;
   logic             i_opm;
   logic             i_arpe;
   logic             i_uie;
   logic [CNT_W-1:0] i_psc;
   logic [CNT_W-1:0] i_arr;
   logic             i_ug;
   logic             i_uif_clr;
   logic [CNT_W-1:0] o_cnt;
   logic             o_uif;
   logic             o_irq;
   logic             o_uev;
   logic             o_cen_clr;

   int unsigned n_checks;
   int unsigned n_errors;

   tim6_update_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_cen     (i_cen),
      .i_udis    (i_udis),
      .i_opm     (i_opm),
      .i_arpe    (i_arpe),
      .i_uie     (i_uie),
      .i_psc     (i_psc),
      .i_arr     (i_arr),
      .i_ug      (i_ug),
      .i_uif_clr (i_uif_clr),
      .o_cnt     (o_cnt),
      .o_uif     (o_uif),
      .o_irq     (o_irq),
      .o_uev     (o_uev),
      .o_cen_clr (o_cen_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Advance n clock edges; inputs change and outputs are sampled 1ns after.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ug_pulse();
      i_ug = 1'b1;
      step(1);
      i_ug = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      i_cen     = 1'b0;
      i_udis    = 1'b0;
      i_opm     = 1'b0;
      i_arpe    = 1'b0;
      i_uie     = 1'b1;
      i_psc     = '0;
      i_arr     = 16'd3;
      i_ug      = 1'b0;
      i_uif_clr = 1'b0;

      // Reset state
      step(2);
      check("rst_cnt", 32'(o_cnt), 32'd0);
      check("rst_uif", 32'(o_uif), 32'd0);
      check("rst_uev", 32'(o_uev), 32'd0);
      check("rst_cenclr", 32'(o_cen_clr), 32'd0);
      check("rst_irq", 32'(o_irq), 32'd0);
      rst = 1'b1;

      // 1: PSC=0 ARR=3, UG then free-run 0,1,2,3,0
      ug_pulse();
      check("t1_ug_uev", 32'(o_uev), 32'd1);
      check("t1_ug_uif", 32'(o_uif), 32'd1);
      check("t1_ug_irq", 32'(o_irq), 32'd1);
      i_cen     = 1'b1;
      i_uif_clr = 1'b1;
      step(1);
      i_uif_clr = 1'b0;
      check("t1_cnt1", 32'(o_cnt), 32'd1);
      check("t1_uifclr", 32'(o_uif), 32'd0);
      check("t1_uev_off", 32'(o_uev), 32'd0);
      step(1);
      check("t1_cnt2", 32'(o_cnt), 32'd2);
      step(1);
      check("t1_cnt3", 32'(o_cnt), 32'd3);
      step(1);
      check("t1_wrap_cnt", 32'(o_cnt), 32'd0);
      check("t1_wrap_uev", 32'(o_uev), 32'd1);
      check("t1_wrap_uif", 32'(o_uif), 32'd1);
      step(1);
      check("t1_uev_pulse", 32'(o_uev), 32'd0);
      step(3);
      check("t1_wrap2_uev", 32'(o_uev), 32'd1);
      check("t1_wrap2_cnt", 32'(o_cnt), 32'd0);

      // 2: PSC=2 ARR=1, count every 3 cycles, UEV every 6
      i_cen = 1'b0;
      i_psc = 16'd2;
      i_arr = 16'd1;
      ug_pulse();
      i_cen = 1'b1;
      step(2);
      check("t2_cnt_p2", 32'(o_cnt), 32'd0);
      step(1);
      check("t2_cnt_p3", 32'(o_cnt), 32'd1);
      step(3);
      check("t2_wrap_cnt", 32'(o_cnt), 32'd0);
      check("t2_wrap_uev", 32'(o_uev), 32'd1);
      step(1);
      i_psc = 16'd0;
      step(1);
      check("t2_oldrate_a", 32'(o_cnt), 32'd0);
      step(1);
      check("t2_oldrate_b", 32'(o_cnt), 32'd1);
      step(3);
      check("t2_wrap2_uev", 32'(o_uev), 32'd1);
      step(1);
      check("t2_newrate_a", 32'(o_cnt), 32'd1);
      step(1);
      check("t2_newrate_b", 32'(o_cnt), 32'd0);
      check("t2_newrate_uev", 32'(o_uev), 32'd1);

      // 3: ARPE=1 shadowed ARR, then ARPE=0 direct ARR
      i_cen  = 1'b0;
      i_arpe = 1'b1;
      i_psc  = 16'd0;
      i_arr  = 16'd5;
      ug_pulse();
      i_cen = 1'b1;
      step(1);
      check("t3_cnt1", 32'(o_cnt), 32'd1);
      i_arr = 16'd2;
      step(4);
      check("t3_reach5", 32'(o_cnt), 32'd5);
      step(1);
      check("t3_wrap5", 32'(o_cnt), 32'd0);
      check("t3_wrap5_uev", 32'(o_uev), 32'd1);
      step(2);
      check("t3_cnt2", 32'(o_cnt), 32'd2);
      step(1);
      check("t3_wrap2", 32'(o_cnt), 32'd0);
      i_cen = 1'b0;
      i_arr = 16'd5;
      ug_pulse();
      i_arpe = 1'b0;
      i_cen  = 1'b1;
      step(1);
      check("t3b_cnt1", 32'(o_cnt), 32'd1);
      i_arr = 16'd2;
      step(1);
      check("t3b_cnt2", 32'(o_cnt), 32'd2);
      step(1);
      check("t3b_wrap2", 32'(o_cnt), 32'd0);
      check("t3b_wrap2_uev", 32'(o_uev), 32'd1);

      // 4: UIE gating and set-beats-clear
      i_cen = 1'b0;
      i_arr = 16'd3;
      i_uie = 1'b0;
      ug_pulse();
      i_cen     = 1'b1;
      i_uif_clr = 1'b1;
      step(1);
      i_uif_clr = 1'b0;
      check("t4_cleared", 32'(o_uif), 32'd0);
      step(3);
      check("t4_ovf_uif", 32'(o_uif), 32'd1);
      check("t4_ovf_irq", 32'(o_irq), 32'd0);
      i_uie = 1'b1;
      #1;
      check("t4_irq_rise", 32'(o_irq), 32'd1);
      i_uie = 1'b0;
      #1;
      check("t4_irq_fall", 32'(o_irq), 32'd0);
      check("t4_uif_kept", 32'(o_uif), 32'd1);
      i_uie = 1'b1;
      step(3);
      check("t4_cnt3", 32'(o_cnt), 32'd3);
      i_uif_clr = 1'b1;
      step(1);
      i_uif_clr = 1'b0;
      check("t4_setwins", 32'(o_uif), 32'd1);
      check("t4_setwins_cnt", 32'(o_cnt), 32'd0);
      i_uif_clr = 1'b1;
      step(1);
      i_uif_clr = 1'b0;
      check("t4_clr_uif", 32'(o_uif), 32'd0);
      check("t4_clr_irq", 32'(o_irq), 32'd0);

      // 5: UDIS=1 wraps without UEV/UIF or shadow load
      i_cen = 1'b0;
      i_arr = 16'd3;
      ug_pulse();
      i_uif_clr = 1'b1;
      step(1);
      i_uif_clr = 1'b0;
      i_udis = 1'b1;
      i_arpe = 1'b1;
      i_arr  = 16'd1;
      i_cen  = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check("t5_no_uev", 32'(o_uev), 32'd0);
      end
      check("t5_wrap_cnt", 32'(o_cnt), 32'd0);
      check("t5_no_uif", 32'(o_uif), 32'd0);
      step(3);
      check("t5_old_arr", 32'(o_cnt), 32'd3);
      i_udis = 1'b0;
      i_arpe = 1'b0;

      // 6: one-pulse mode, restart, then reset mid-count
      i_cen = 1'b0;
      i_opm = 1'b1;
      i_arr = 16'd2;
      ug_pulse();
      i_cen = 1'b1;
      step(2);
      check("t6_cnt2", 32'(o_cnt), 32'd2);
      check("t6_no_cenclr", 32'(o_cen_clr), 32'd0);
      step(1);
      check("t6_stop_cnt", 32'(o_cnt), 32'd0);
      check("t6_cenclr", 32'(o_cen_clr), 32'd1);
      step(1);
      check("t6_cenclr_pulse", 32'(o_cen_clr), 32'd0);
      check("t6_held_a", 32'(o_cnt), 32'd0);
      step(2);
      check("t6_held_b", 32'(o_cnt), 32'd0);
      i_cen = 1'b0;
      step(1);
      i_cen = 1'b1;
      step(1);
      check("t6_resume1", 32'(o_cnt), 32'd1);
      step(1);
      check("t6_resume2", 32'(o_cnt), 32'd2);
      rst = 1'b0;
      step(1);
      check("t6_rst_cnt", 32'(o_cnt), 32'd0);
      check("t6_rst_uif", 32'(o_uif), 32'd0);
      check("t6_rst_uev", 32'(o_uev), 32'd0);
      check("t6_rst_cenclr", 32'(o_cen_clr), 32'd0);
      check("t6_rst_irq", 32'(o_irq), 32'd0);

      // ARR=0 boundary: counter parked, no overflow
      i_opm = 1'b0;
      i_arr = 16'd0;
      rst   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         check("arr0_cnt", 32'(o_cnt), 32'd0);
         check("arr0_uev", 32'(o_uev), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tim6_update_ctrl.md
Name: tim6_update_ctrl

Overview:
- Counting and interrupt-generation side of basic timer TIM6.
- Consumes the UIE enable held in the DIER register, the CR1 control bits, and the PSC/ARR preload values.
- Produces the counter, the update event (UEV), the UIF status flag and the interrupt request to the NVIC.
- Sits between the TIM6 register file and the interrupt controller.

Parameters:
- CNT_W, 16, width of counter, prescaler, ARR and PSC.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- i_cen  input  1  CR1.CEN counter enable
- i_udis  input  1  CR1.UDIS, update disable
- i_opm  input  1  CR1.OPM, one-pulse mode
- i_arpe  input  1  CR1.ARPE, ARR preload enable
- i_uie  input  1  DIER.UIE update interrupt enable
- i_psc  input  CNT_W  PSC preload value
- i_arr  input  CNT_W  ARR preload value
- i_ug  input  1  EGR.UG software update, one-cycle pulse
- i_uif_clr  input  1  SR.UIF clear strobe, one-cycle pulse
- o_cnt  output  CNT_W  current counter value
- o_uif  output  1  SR.UIF status flag
- o_irq  output  1  interrupt request
- o_uev  output  1  update event pulse (TRGO source)
- o_cen_clr  output  1  request to CR1 to clear CEN (OPM)

Behaviour:
- Reset (rst=0 at a clk edge):
  - psc_cnt, o_cnt, o_uif, o_uev, o_cen_clr and opm_hold all go to 0.
  - psc_shadow goes to 0; arr_shadow goes to all-ones.
- Active ARR: arr_act = arr_shadow when i_arpe=1, else i_arr taken directly.
- Run condition: run = i_cen & ~opm_hold & ~i_ug.
- Prescaler:
  - When run, psc_cnt increments each clk.
  - When psc_cnt == psc_shadow, psc_cnt returns to 0 and a one-cycle internal tick occurs.
  - psc_shadow=0 gives a tick every cycle.
- Counter:
  - On tick, if o_cnt == arr_act then o_cnt <= 0 and an overflow occurs; otherwise o_cnt <= o_cnt+1.
  - arr_act=0: counter held at 0, overflow never generated, prescaler still runs.
- UG:
  - i_ug=1 takes priority over any tick in the same cycle.
  - psc_cnt and o_cnt go to 0 next cycle.
  - A UEV is requested regardless of i_cen.
- UEV request sources: overflow, or i_ug.
- If i_udis=0, the request produces a UEV:
  - o_uev=1 for exactly one cycle (the cycle after the request edge).
  - psc_shadow <= i_psc and arr_shadow <= i_arr on the same edge.
  - o_uif set to 1.
- If i_udis=1:
  - Counter and prescaler still wrap/reset.
  - No shadow load, no o_uev, no o_uif set.
- UIF:
  - Sticky until i_uif_clr=1, which clears it next cycle.
  - Set and clear in the same cycle: set wins, o_uif stays 1.
- IRQ: o_irq = o_uif & i_uie, combinational level.
  - Toggling i_uie while o_uif=1 asserts/deasserts o_irq immediately.
  - UIF is not affected by i_uie.
- One-pulse mode: on an overflow with i_opm=1, regardless of i_udis:
  - opm_hold <= 1 and o_cen_clr=1 for one cycle.
  - Counter stops at 0.
  - opm_hold clears when i_cen=0 is sampled.
  - A UG-generated UEV does not trigger OPM stop.
- i_cen=0: counter and prescaler hold their values; shadows unchanged.
- Latency:
  - o_cnt changes on the edge after the tick condition.
  - o_uev, o_uif and o_cen_clr appear on the edge that wraps o_cnt to 0.
- Reset mid-count discards all state, including pending shadow loads.

Test Plan:
1. Reset, then i_psc=0, i_arr=3, i_ug pulse, i_cen=1 → shadows loaded, o_uif=1 after UG. Clear UIF, then count o_cnt 0,1,2,3,0. o_uev pulses every 4 cycles; o_uif sets on each wrap.
2. i_psc=2, i_arr=1, UG then i_cen=1 → o_cnt advances every 3 cycles; UEV period is 6 cycles. Change i_psc to 0 mid-period → new rate only after the next UEV.
3. i_arpe=1, arr_shadow=5: write i_arr=2 with o_cnt=1 → counter still reaches 5 before wrapping; the next period wraps at 2. Repeat with i_arpe=0 → wraps at 2 immediately.
4. i_uie=0 during an overflow → o_uif=1, o_irq=0. Raise i_uie → o_irq=1 in the same cycle. Pulse i_uif_clr coincident with a new overflow → o_uif remains 1.
5. i_udis=1, i_arr=3 → o_cnt wraps 3→0 with no o_uev and no o_uif. A shadow change from a new i_arr does not take effect.
6. i_opm=1, i_arr=2, i_cen=1 → after 3 ticks o_cnt=0, o_cen_clr=1 for one cycle, and counting stops while i_cen stays 1. Drop i_cen, then raise it → counting resumes. Assert rst mid-count → all outputs 0 on the next edge.
